relu_maxpool2: RTL and testbench

RELU_MAXPOOL2 -- requirements
Module: relu_maxpool2

---
 rtl/cnn_pool_pkg.sv | 30 +++
 rtl/pool_line_buf.sv | 26 ++
 rtl/relu_maxpool2.sv | 98 +++++++++
 tb/tb_relu_maxpool2.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types for the CNN pooling stage: nine signed 16-bit channels per pixel,
// packed channel k at bits [16k+15:16k], plus per-channel selection helpers.
package cnn_pool_pkg;

   localparam int unsigned NUM_CH = 9;
   localparam int unsigned DW     = 16;
   localparam int unsigned BUS_W  = NUM_CH * DW;

   typedef logic signed [DW-1:0] pix_t;
   typedef pix_t [NUM_CH-1:0]    vec_t;

   // Per-channel signed max; ties return the shared value.
   function automatic vec_t chmax(vec_t a, vec_t b);
      vec_t m;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         m[i] = ($signed(a[i]) > $signed(b[i])) ? a[i] : b[i];
      end
      return m;
   endfunction

   // Clamp negative channels to zero.
   function automatic vec_t relu(vec_t a);
      vec_t m;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         m[i] = a[i][DW-1] ? '0 : a[i];
      end
      return m;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the even row.
// Single write port, asynchronous read; contents are never reset.
module pool_line_buf
   import cnn_pool_pkg::*;
#(
   parameter int unsigned DEPTH = 12,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  vec_t          wdata,
   output vec_t          rdata_c
);

   vec_t mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata_c = mem[addr];

endmodule

// File: rtl/relu_maxpool2.sv
// Optional ReLU followed by 2x2 stride-2 max pooling over a raster-ordered map.
// Define RELU_MAXPOOL2_RELU_EN to clamp negative channels before pooling.
module relu_maxpool2
   import cnn_pool_pkg::*;
#(
   parameter int unsigned IMG_W = 24,
   parameter int unsigned IMG_H = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] pw_in,
   input  logic             valid_in,
   output logic [BUS_W-1:0] pool_out,
   output logic             valid_out,
   output logic             frame_done
);

   localparam int unsigned CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned LB_DEPTH = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
   localparam int unsigned AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
      $error("relu_maxpool2: IMG_W must be even and non-zero");
   end
   if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
      $error("relu_maxpool2: IMG_H must be even and non-zero");
   end

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   vec_t          hreg;
   vec_t          cur_c;
   vec_t          hmax_c;
   vec_t          lb_rd_c;
   logic [AW-1:0] lb_addr_c;
   logic          col_last_c;
   logic          row_last_c;
   logic          lb_we_c;
   logic          pool_c;

   // Pixel conditioning, horizontal max and FILL/POOL decode (row[0] is the phase).
   always_comb begin
      cur_c = vec_t'(pw_in);
`ifdef RELU_MAXPOOL2_RELU_EN
      cur_c = relu(vec_t'(pw_in));
`endif
      hmax_c     = chmax(hreg, cur_c);
      col_last_c = (col == COL_LAST);
      row_last_c = (row == ROW_LAST);
      lb_addr_c  = AW'(col >> 1);
      lb_we_c    = !rst && valid_in && col[0] && !row[0];
      pool_c     = !rst && valid_in && col[0] && row[0];
   end

   pool_line_buf #(
      .DEPTH (LB_DEPTH),
      .AW    (AW)
   ) u_line_buf (
      .clk     (clk),
      .we      (lb_we_c),
      .addr    (lb_addr_c),
      .wdata   (hmax_c),
      .rdata_c (lb_rd_c)
   );

   // Raster counters, horizontal hold register and registered pooled output.
   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         hreg       <= '0;
         pool_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= pool_c;
         frame_done <= pool_c && col_last_c && row_last_c;
         if (valid_in) begin
            if (!col[0]) begin
               hreg <= cur_c;
            end
            if (col_last_c) begin
               col <= '0;
               row <= row_last_c ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (pool_c) begin
            pool_out <= chmax(hmax_c, lb_rd_c);
         end
      end
   end

endmodule

// File: tb/tb_relu_maxpool2.sv
// Directed bench for relu_maxpool2: a 4x4 instance with hand-computed windows and a
// 24x24 instance checked against a full-frame 2x2 reference, including latency.
module tb_relu_maxpool2;
   import cnn_pool_pkg::*;

   localparam int SW = 4;
   localparam int SH = 4;
   localparam int BW = 24;
   localparam int BH = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic [BUS_W-1:0] pw_s, pw_b, po_s, po_b;
   logic             vin_s, vin_b, vo_s, vo_b, fd_s, fd_b;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stray_fd = 0;

   vec_t got_s [$];
   bit   fdg_s [$];
   vec_t got_b [$];
   bit   fdg_b [$];
   int   cyg_b [$];
   vec_t exp_b [$];
   bit   fde_b [$];
   int   cye_b [$];
   vec_t frame [BH][BW];

   relu_maxpool2 #(.IMG_W(SW), .IMG_H(SH)) u_small (
      .clk        (clk),
      .rst        (rst),
      .pw_in      (pw_s),
      .valid_in   (vin_s),
      .pool_out   (po_s),
      .valid_out  (vo_s),
      .frame_done (fd_s)
   );

   relu_maxpool2 #(.IMG_W(BW), .IMG_H(BH)) u_big (
      .clk        (clk),
      .rst        (rst),
      .pw_in      (pw_b),
      .valid_in   (vin_b),
      .pool_out   (po_b),
      .valid_out  (vo_b),
      .frame_done (fd_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vo_s) begin
         got_s.push_back(po_s);
         fdg_s.push_back(fd_s);
      end
      if (vo_b) begin
         got_b.push_back(po_b);
         fdg_b.push_back(fd_b);
         cyg_b.push_back(cyc);
      end
      if ((fd_s && !vo_s) || (fd_b && !vo_b)) stray_fd++;
   end

   task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic pix_t mrelu(pix_t v);
`ifdef RELU_MAXPOOL2_RELU_EN
      if (v < 0) return 16'sd0;
`endif
      return v;
   endfunction

   function automatic pix_t max4(pix_t a, pix_t b, pix_t c, pix_t d);
      pix_t m;
      m = mrelu(a);
      if (mrelu(b) > m) m = mrelu(b);
      if (mrelu(c) > m) m = mrelu(c);
      if (mrelu(d) > m) m = mrelu(d);
      return m;
   endfunction

   task automatic run_small(input vec_t px [16], input int gap);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pw_s  = px[i];
         vin_s = 1'b1;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            vin_s = 1'b0;
            pw_s  = '1;
         end
      end
      @(negedge clk);
      vin_s = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_small(input string tag, input vec_t ex [4]);
      check({tag, "_cnt"}, BUS_W'(got_s.size()), BUS_W'(4));
      for (int i = 0; i < 4 && i < got_s.size(); i++) begin
         check($sformatf("%s_val%0d", tag, i), got_s[i], ex[i]);
         check($sformatf("%s_fd%0d", tag, i), BUS_W'(fdg_s[i]), BUS_W'(i == 3));
      end
      got_s.delete();
      fdg_s.delete();
   endtask

   task automatic drive_big(input int npix, input int duty);
      for (int p = 0; p < npix; p++) begin
         int   r;
         int   c;
         vec_t v;
         vec_t e;
         r = (p / BW) % BH;
         c = p % BW;
         for (int k = 0; k < NUM_CH; k++) begin
            v[k] = pix_t'($urandom());
            if ($urandom_range(7) == 0) v[k] = 16'sh7fff;
            else if ($urandom_range(7) == 0) v[k] = 16'sh8000;
         end
         while (duty < 100 && int'($urandom_range(99)) >= duty) begin
            @(negedge clk);
            vin_b = 1'b0;
            pw_b  = BUS_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         end
         @(negedge clk);
         pw_b        = v;
         vin_b       = 1'b1;
         frame[r][c] = v;
         if ((r % 2) == 1 && (c % 2) == 1) begin
            for (int k = 0; k < NUM_CH; k++) begin
               e[k] = max4(frame[r-1][c-1][k], frame[r-1][c][k], frame[r][c-1][k], v[k]);
            end
            exp_b.push_back(e);
            fde_b.push_back(r == BH - 1 && c == BW - 1);
            cye_b.push_back(cyc + 1);
         end
      end
   endtask

   task automatic compare_big(input string tag, input int nfd_exp);
      int nfd;
      nfd = 0;
      foreach (fdg_b[i]) if (fdg_b[i]) nfd++;
      check({tag, "_cnt"}, BUS_W'(got_b.size()), BUS_W'(exp_b.size()));
      check({tag, "_nfd"}, BUS_W'(nfd), BUS_W'(nfd_exp));
      for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
         check($sformatf("%s_val%0d", tag, i), got_b[i], exp_b[i]);
         check($sformatf("%s_fd%0d", tag, i), BUS_W'(fdg_b[i]), BUS_W'(fde_b[i]));
         check($sformatf("%s_lat%0d", tag, i), BUS_W'(cyg_b[i]), BUS_W'(cye_b[i]));
      end
      got_b.delete(); fdg_b.delete(); cyg_b.delete();
      exp_b.delete(); fde_b.delete(); cye_b.delete();
   endtask

   initial begin
      vec_t px [16];
      vec_t ex [4];

      // Reset with a valid pixel presented to the small instance: it must be ignored.
      rst   = 1'b1;
      vin_s = 1'b1;
      pw_s  = {NUM_CH{16'sh0055}};
      vin_b = 1'b0;
      pw_b  = '0;
      repeat (3) @(negedge clk);
      check("rst_pool_s", po_s, '0);
      check("rst_valid_s", BUS_W'(vo_s), '0);
      check("rst_fd_s", BUS_W'(fd_s), '0);
      check("rst_pool_b", po_b, '0);
      check("rst_valid_b", BUS_W'(vo_b), '0);
      rst   = 1'b0;
      vin_s = 1'b0;

      // 4x4 ramp on ch0: windows give 6, 8, 14, 16.
      for (int i = 0; i < 16; i++) begin
         px[i]    = '0;
         px[i][0] = 16'(i + 1);
      end
      for (int i = 0; i < 4; i++) ex[i] = '0;
      ex[0][0] = 16'sd6;
      ex[1][0] = 16'sd8;
      ex[2][0] = 16'sd14;
      ex[3][0] = 16'sd16;
      run_small(px, 0);
      check_small("ramp", ex);
      check("hold_pool", po_s, ex[3]);
      check("hold_valid", BUS_W'(vo_s), '0);
      run_small(px, 2);
      check_small("ramp_gap", ex);

      // Negatives, extremes, ties and an all-negative channel.
      for (int i = 0; i < 16; i++) px[i] = '0;
      px[0][3] = -16'sd5;
      px[1][3] = -16'sd2;
      px[4][3] = -16'sd9;
      px[5][3] = -16'sd1;
      for (int k = 0; k < NUM_CH; k++) begin
         px[2][k]  = 16'sh7fff;
         px[3][k]  = 16'sh8000;
         px[6][k]  = 16'sd0;
         px[7][k]  = 16'sd100;
         px[8][k]  = 16'sd7;
         px[9][k]  = 16'sd7;
         px[12][k] = 16'sd7;
         px[13][k] = 16'sd7;
      end
      px[10][8] = -16'sd3;
      px[11][8] = -16'sd3;
      px[14][8] = -16'sd3;
      px[15][8] = -16'sd3;
      for (int i = 0; i < 4; i++) ex[i] = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ex[1][k] = 16'sh7fff;
         ex[2][k] = 16'sd7;
      end
`ifdef RELU_MAXPOOL2_RELU_EN
      ex[0][3] = 16'sd0;
      ex[3][8] = 16'sd0;
`else
      ex[0][3] = -16'sd1;
      ex[3][8] = -16'sd3;
`endif
      run_small(px, 1);
      check_small("mix", ex);

      // 24x24: sparse frame then back-to-back frame.
      drive_big(BW * BH, 50);
      drive_big(BW * BH, 100);
      @(negedge clk);
      vin_b = 1'b0;
      repeat (3) @(negedge clk);
      compare_big("big2", 2);

      // Reset 30 pixels into a frame, then a full frame from (0,0).
      drive_big(30, 100);
      @(negedge clk);
      rst   = 1'b1;
      vin_b = 1'b1;
      pw_b  = {NUM_CH{16'sh1234}};
      @(negedge clk);
      check("midrst_pool", po_b, '0);
      check("midrst_valid", BUS_W'(vo_b), '0);
      rst   = 1'b0;
      vin_b = 1'b0;
      drive_big(BW * BH, 70);
      @(negedge clk);
      vin_b = 1'b0;
      repeat (3) @(negedge clk);
      compare_big("after_rst", 1);

      check("stray_fd", BUS_W'(stray_fd), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
